reg_file_funsel: RTL and testbench

- Multi-register storage stage that sits directly downstream of the single FunSel register cell.
- Instantiates NUM_REGS registers that share that cell's FunSel operation set (clear / load / increment / decrement) behind a common write bus.
- Two independent combinational read ports feed the ALU-side operand buses.
- Storage is clocked; per-register write enables come from a selection mask driven by the control sequencer.

---
 rtl/reg_file_funsel.sv | 42 ++++
 tb/tb_reg_file_funsel.sv | 116 +++++++++++
 2 files changed

// File: rtl/reg_file_funsel.sv
// reg_file_funsel: NUM_REGS registers sharing one FunSel write bus (clear/load/inc/dec),
// two combinational read ports and a per-register zero flag.
module reg_file_funsel #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          FunSel,
    input  logic [WIDTH-1:0]    data_in,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [1:0]          OutASel,
    input  logic [1:0]          OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic [NUM_REGS-1:0] Zero
);
    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] w_next [NUM_REGS];
    logic [WIDTH-1:0] w_pad  [4];
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_comb
            w_next[g] = FunSel[1] ? (FunSel[0] ? r_regs[g] - WIDTH'(1) : r_regs[g] + WIDTH'(1))
                                  : (FunSel[0] ? data_in : '0);
        always_ff @(posedge clk or posedge rst)
            if (rst)
                r_regs[g] <= '0;
            else if (RegSel[g])
                r_regs[g] <= w_next[g];
        assign Zero[g] = (r_regs[g] == '0);
    end
    // read ports see a 4-entry view; indices without a register read as 0
    for (genvar g = 0; g < 4; g++) begin : g_pad
        if (g < NUM_REGS) begin : g_real
            assign w_pad[g] = r_regs[g];
        end else begin : g_none
            assign w_pad[g] = '0;
        end
    end
    assign OutA = w_pad[OutASel];
    assign OutB = w_pad[OutBSel];
endmodule

// File: tb/tb_reg_file_funsel.sv
// tb_reg_file_funsel: directed vectors for reg_file_funsel, table loop plus hand-written
// reset sequences; each vector also checks OutA before the edge to prove there is no bypass.
module tb_reg_file_funsel;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] FunSel, OutASel, OutBSel;
    logic [7:0] data_in, OutA, OutB;
    logic [3:0] RegSel, Zero;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] fun;
        logic [7:0] din;
        logic [3:0] sel;
        logic [1:0] asel, bsel;
        logic [7:0] pre_a, ea, eb;
        logic [3:0] ez;
    } vec_t;
    vec_t tv [15];

    reg_file_funsel #(.WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst), .FunSel(FunSel), .data_in(data_in), .RegSel(RegSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] a, input logic [1:0] b,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] ez);
        OutASel = a;
        OutBSel = b;
        #1;
        n_vec++;
        if (OutA !== ea || OutB !== eb || Zero !== ez) begin
            n_err++;
            $display("FAIL %s: got OutA=%h OutB=%h Zero=%b, want OutA=%h OutB=%h Zero=%b",
                     nm, OutA, OutB, Zero, ea, eb, ez);
        end
    endtask

    task automatic chk_a(input string nm, input logic [7:0] ea);
        n_vec++;
        if (OutA !== ea) begin
            n_err++;
            $display("FAIL %s: got OutA=%h, want OutA=%h", nm, OutA, ea);
        end
    endtask

    initial begin
        //            fun    din    sel      as  bs  pre    A      B      Zero
        tv[0]  = '{2'b00, 8'hFF, 4'b1111, 1, 1, 8'hFF, 8'h00, 8'h00, 4'b1111};
        tv[1]  = '{2'b01, 8'hA5, 4'b0100, 2, 0, 8'h00, 8'hA5, 8'h00, 4'b1011};
        tv[2]  = '{2'b01, 8'hFF, 4'b0010, 1, 2, 8'h00, 8'hFF, 8'hA5, 4'b1001};
        tv[3]  = '{2'b10, 8'h00, 4'b0010, 1, 1, 8'hFF, 8'h00, 8'h00, 4'b1011};
        tv[4]  = '{2'b11, 8'h00, 4'b0010, 1, 2, 8'h00, 8'hFF, 8'hA5, 4'b1001};
        tv[5]  = '{2'b01, 8'h03, 4'b0001, 0, 3, 8'h00, 8'h03, 8'h00, 4'b1000};
        tv[6]  = '{2'b01, 8'h07, 4'b1000, 3, 0, 8'h00, 8'h07, 8'h03, 4'b0000};
        tv[7]  = '{2'b11, 8'h00, 4'b1001, 0, 3, 8'h03, 8'h02, 8'h06, 4'b0000};
        tv[8]  = '{2'b11, 8'h00, 4'b1001, 0, 3, 8'h02, 8'h01, 8'h05, 4'b0000};
        tv[9]  = '{2'b11, 8'h00, 4'b1001, 0, 3, 8'h01, 8'h00, 8'h04, 4'b0001};
        tv[10] = '{2'b01, 8'h5A, 4'b0000, 1, 2, 8'hFF, 8'hFF, 8'hA5, 4'b0001};
        tv[11] = '{2'b01, 8'h5A, 4'b0000, 3, 0, 8'h04, 8'h04, 8'h00, 4'b0001};
        tv[12] = '{2'b11, 8'h00, 4'b0001, 0, 0, 8'h00, 8'hFF, 8'hFF, 4'b0000};
        tv[13] = '{2'b10, 8'h00, 4'b1001, 0, 3, 8'hFF, 8'h00, 8'h05, 4'b0001};
        tv[14] = '{2'b00, 8'hFF, 4'b1111, 2, 2, 8'hA5, 8'h00, 8'h00, 4'b1111};

        rst = 1'b1; FunSel = 2'b00; data_in = 8'h00; RegSel = 4'b0000;
        OutASel = 2'd0; OutBSel = 2'd3;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("reset_state", 0, 3, 8'h00, 8'h00, 4'b1111);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            FunSel = 2'b01; data_in = 8'h11 * (i + 1); RegSel = 4'(1 << i);
            @(posedge clk);
        end
        @(negedge clk) RegSel = 4'b0000;
        chk("preload_r0_r3", 0, 3, 8'h11, 8'h44, 4'b0000);
        chk("preload_r1_r2", 1, 2, 8'h22, 8'h33, 4'b0000);
        #1 rst = 1'b1;
        chk("async_reset_now", 0, 3, 8'h00, 8'h00, 4'b1111);
        FunSel = 2'b01; data_in = 8'hFF; RegSel = 4'b1111;
        @(posedge clk); #1;
        chk("edge_ignored_in_reset", 1, 2, 8'h00, 8'h00, 4'b1111);
        rst = 1'b0;
        chk("release_no_update", 0, 3, 8'h00, 8'h00, 4'b1111);
        @(posedge clk); #1;
        chk("first_edge_after_release", 0, 3, 8'hFF, 8'hFF, 4'b0000);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            FunSel = tv[i].fun; data_in = tv[i].din; RegSel = tv[i].sel;
            OutASel = tv[i].asel; OutBSel = tv[i].bsel;
            #1;
            chk_a($sformatf("vec%0d_pre_edge", i), tv[i].pre_a);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), tv[i].asel, tv[i].bsel, tv[i].ea, tv[i].eb, tv[i].ez);
        end

        @(negedge clk);
        FunSel = 2'b10; RegSel = 4'b0100; OutASel = 2'd2; OutBSel = 2'd2;
        repeat (5) @(posedge clk);
        #1;
        chk("r2_counts_to_5", 2, 2, 8'h05, 8'h05, 4'b1011);
        #2 rst = 1'b1;
        chk("r2_async_drop", 2, 2, 8'h00, 8'h00, 4'b1111);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("r2_inc_after_release", 2, 0, 8'h01, 8'h00, 4'b1011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
